// File: rtl/load_ext_pkg.sv
// Shared definitions for the load extension unit: load-type encodings,
// FSM state encoding and small decode helpers.
package load_ext_pkg;

    typedef enum logic [2:0] {
        OP_NONE = 3'b000,
        OP_LW   = 3'b001,
        OP_LBU  = 3'b010,
        OP_LB   = 3'b011,
        OP_LHU  = 3'b100,
        OP_LH   = 3'b101
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_REQ  = 2'b01,
        ST_WAIT = 2'b10,
        ST_RSP  = 2'b11
    } state_e;

    // True for the five real load types; NONE and 110/111 start no transaction.
    function automatic logic op_is_load(input logic [2:0] op);
        return (op == OP_LW)  || (op == OP_LBU) || (op == OP_LB) ||
               (op == OP_LHU) || (op == OP_LH);
    endfunction

    // Word loads need offset 00, halfword loads need an even offset.
    function automatic logic is_misaligned(input logic [2:0] op, input logic [1:0] off);
        return ((op == OP_LW) && (off != 2'b00)) ||
               (((op == OP_LHU) || (op == OP_LH)) && off[0]);
    endfunction

endpackage

// File: rtl/load_ext_extract.sv
// Combinational slicer/extender: picks the byte or halfword selected by the
// byte offset out of a raw memory word and zero- or sign-extends it.
module load_ext_extract
    import load_ext_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  offset,
    input  logic [2:0]  op,
    output logic [31:0] data
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    // Select the addressed byte/halfword, then extend according to load type.
    always_comb begin
        byte_sel = 8'h00;
        half_sel = 16'h0000;
        data     = 32'h0000_0000;
        case (offset)
            2'd0:    byte_sel = rdata[7:0];
            2'd1:    byte_sel = rdata[15:8];
            2'd2:    byte_sel = rdata[23:16];
            default: byte_sel = rdata[31:24];
        endcase
        // Only offset[1] picks the half; an odd offset is either trapped
        // earlier by the alignment check or deliberately ignored.
        half_sel = offset[1] ? rdata[31:16] : rdata[15:0];
        case (op)
            OP_LW:   data = rdata;
            OP_LBU:  data = {24'h00_0000, byte_sel};
            OP_LB:   data = {{24{byte_sel[7]}}, byte_sel};
            OP_LHU:  data = {16'h0000, half_sel};
            OP_LH:   data = {{16{half_sel[15]}}, half_sel};
            default: data = 32'h0000_0000;
        endcase
    end

endmodule

// File: rtl/load_ext.sv
// Load extension unit: accepts a load request from the pipeline, issues one
// word read to data memory, and returns the sliced/extended result.
// Optional build macro: LOAD_ALIGN_CHECK_EN -- when defined, misaligned LW
// and LH/LHU loads skip memory and return rsp_err=1 with rsp_data=0.
//
//   state   | meaning
//   --------+-------------------------------------------------
//   IDLE    | ready for a request (req_ready=1, busy=0)
//   REQ     | mem_req asserted, waiting for mem_gnt
//   WAIT    | read granted, waiting for mem_rvalid
//   RSP     | rsp_valid asserted, waiting for rsp_ready
module load_ext
    import load_ext_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [2:0]        req_op,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_gnt,
    input  logic              mem_rvalid,
    input  logic [31:0]       mem_rdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [31:0]       rsp_data,
    output logic              rsp_err,
    output logic              busy
);

    state_e      state;
    logic [1:0]  off_q;
    logic [2:0]  op_q;
    logic [31:0] ext_data;

    load_ext_extract u_extract (
        .rdata  (mem_rdata),
        .offset (off_q),
        .op     (op_q),
        .data   (ext_data)
    );

`ifndef LOAD_ALIGN_CHECK_EN
    // Without the alignment check there is no error condition.
    assign rsp_err = 1'b0;
`endif

    // Sequencing FSM; every handshake output is a register so it stays
    // stable for as long as the state holds.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= ST_IDLE;
            req_ready <= 1'b1;
            busy      <= 1'b0;
            mem_req   <= 1'b0;
            mem_addr  <= '0;
            rsp_valid <= 1'b0;
            rsp_data  <= 32'h0000_0000;
            off_q     <= 2'b00;
            op_q      <= OP_NONE;
`ifdef LOAD_ALIGN_CHECK_EN
            rsp_err   <= 1'b0;
`endif
        end else begin
            case (state)
                ST_IDLE: begin
                    if (req_valid && req_ready) begin
                        off_q    <= req_addr[1:0];
                        op_q     <= req_op;
                        mem_addr <= {req_addr[ADDR_W-1:2], 2'b00};
                        if (op_is_load(req_op)) begin
                            req_ready <= 1'b0;
                            busy      <= 1'b1;
`ifdef LOAD_ALIGN_CHECK_EN
                            if (is_misaligned(req_op, req_addr[1:0])) begin
                                state     <= ST_RSP;
                                rsp_valid <= 1'b1;
                                rsp_data  <= 32'h0000_0000;
                                rsp_err   <= 1'b1;
                            end else begin
                                state   <= ST_REQ;
                                mem_req <= 1'b1;
                                rsp_err <= 1'b0;
                            end
`else
                            state   <= ST_REQ;
                            mem_req <= 1'b1;
`endif
                        end
                    end
                end
                ST_REQ: begin
                    if (mem_gnt) begin
                        mem_req <= 1'b0;
                        state   <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (mem_rvalid) begin
                        rsp_data  <= ext_data;
                        rsp_valid <= 1'b1;
                        state     <= ST_RSP;
                    end
                end
                ST_RSP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        req_ready <= 1'b1;
                        busy      <= 1'b0;
                        state     <= ST_IDLE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_load_ext.sv
// Self-checking bench for load_ext: table of load vectors with a response
// scoreboard, plus a hand-written mid-transaction reset sequence.
module tb_load_ext;

`ifdef LOAD_ALIGN_CHECK_EN
    localparam bit ALIGN = 1'b1;
`else
    localparam bit ALIGN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset_n;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic [2:0]  req_op;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_gnt;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_data;
    logic        rsp_err;
    logic        busy;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] addr;
        logic [31:0] rdata;
        int          gnt_dly;
        int          rsp_dly;
        logic        mem_exp;
        logic [31:0] exp_data;
        logic        exp_err;
    } vec_t;

    typedef struct {
        logic [31:0] data;
        logic        err;
    } exp_t;

    exp_t sb[$];
    vec_t vecs[14];
    int   n_checks = 0;
    int   n_fail   = 0;

    load_ext #(.ADDR_W(32)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_addr   (req_addr),
        .req_op     (req_op),
        .mem_req    (mem_req),
        .mem_addr   (mem_addr),
        .mem_gnt    (mem_gnt),
        .mem_rvalid (mem_rvalid),
        .mem_rdata  (mem_rdata),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_data   (rsp_data),
        .rsp_err    (rsp_err),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input string what,
                         input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s.%s: got %h expected %h", tag, what, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_vec(input vec_t v, input string tag);
        exp_t e;
        int   w;
        check(tag, "req_ready_idle", {31'b0, req_ready}, 32'd1);
        req_valid = 1'b1;
        req_addr  = v.addr;
        req_op    = v.op;
        tick();
        req_valid = 1'b0;
        if (v.op == 3'b000 || v.op >= 3'b110) begin
            check(tag, "busy_noop", {31'b0, busy}, 32'd0);
            check(tag, "ready_noop", {31'b0, req_ready}, 32'd1);
            check(tag, "mem_req_noop", {31'b0, mem_req}, 32'd0);
            return;
        end
        check(tag, "busy", {31'b0, busy}, 32'd1);
        check(tag, "req_ready_busy", {31'b0, req_ready}, 32'd0);
        if (v.mem_exp) begin
            check(tag, "mem_req", {31'b0, mem_req}, 32'd1);
            check(tag, "mem_addr", mem_addr, {v.addr[31:2], 2'b00});
            for (int i = 0; i < v.gnt_dly; i++) begin
                mem_gnt    = 1'b0;
                mem_rvalid = 1'b1;       // stray rvalid in REQ must be ignored
                mem_rdata  = 32'hDEAD_BEEF;
                tick();
                mem_rvalid = 1'b0;
                check(tag, "mem_req_hold", {31'b0, mem_req}, 32'd1);
                check(tag, "mem_addr_hold", mem_addr, {v.addr[31:2], 2'b00});
            end
            mem_gnt = 1'b1;
            tick();
            mem_gnt = 1'b0;
            check(tag, "mem_req_drop", {31'b0, mem_req}, 32'd0);
            check(tag, "rsp_valid_wait", {31'b0, rsp_valid}, 32'd0);
            mem_rvalid = 1'b1;
            mem_rdata  = v.rdata;
            sb.push_back('{v.exp_data, v.exp_err});
            tick();
            mem_rvalid = 1'b0;
            mem_rdata  = 32'h0;
        end else begin
            check(tag, "mem_req_none", {31'b0, mem_req}, 32'd0);
            sb.push_back('{v.exp_data, v.exp_err});
        end
        w = 0;
        while (!rsp_valid && w < 20) begin
            tick();
            w++;
        end
        check(tag, "rsp_valid", {31'b0, rsp_valid}, 32'd1);
        if (sb.size() == 0) begin
            check(tag, "scoreboard_empty", 32'd0, 32'd1);
            return;
        end
        e = sb.pop_front();
        for (int i = 0; i < v.rsp_dly; i++) begin
            check(tag, "rsp_valid_hold", {31'b0, rsp_valid}, 32'd1);
            check(tag, "rsp_data_hold", rsp_data, e.data);
            check(tag, "req_ready_hold", {31'b0, req_ready}, 32'd0);
            tick();
        end
        rsp_ready = 1'b1;
        check(tag, "rsp_data", rsp_data, e.data);
        check(tag, "rsp_err", {31'b0, rsp_err}, {31'b0, e.err});
        tick();
        rsp_ready = 1'b0;
        check(tag, "rsp_valid_drop", {31'b0, rsp_valid}, 32'd0);
        check(tag, "req_ready_back", {31'b0, req_ready}, 32'd1);
        check(tag, "busy_back", {31'b0, busy}, 32'd0);
    endtask

    initial begin
        vec_t lbu_after;
        //          op      addr          rdata          g  r  mem     data           err
        vecs[0]  = '{3'b011, 32'h0000_1003, 32'h80FF_1234, 0, 0, 1'b1, 32'hFFFF_FF80, 1'b0};
        vecs[1]  = '{3'b100, 32'h0000_1002, 32'h8001_7FFF, 3, 0, 1'b1, 32'h0000_8001, 1'b0};
        vecs[2]  = '{3'b001, 32'h0000_2000, 32'hCAFE_BABE, 0, 5, 1'b1, 32'hCAFE_BABE, 1'b0};
        vecs[3]  = '{3'b001, 32'h0000_2001, 32'h1234_5678, 0, 0, !ALIGN,
                     ALIGN ? 32'h0 : 32'h1234_5678, ALIGN};
        vecs[4]  = '{3'b010, 32'h0000_0001, 32'h1122_8344, 0, 0, 1'b1, 32'h0000_0083, 1'b0};
        vecs[5]  = '{3'b011, 32'h0000_0000, 32'h0000_007F, 0, 0, 1'b1, 32'h0000_007F, 1'b0};
        vecs[6]  = '{3'b101, 32'h0000_0000, 32'hABCD_8765, 0, 0, 1'b1, 32'hFFFF_8765, 1'b0};
        vecs[7]  = '{3'b101, 32'h0000_0002, 32'h7BCD_8765, 1, 1, 1'b1, 32'h0000_7BCD, 1'b0};
        vecs[8]  = '{3'b010, 32'h0000_0002, 32'hAABB_CCDD, 0, 0, 1'b1, 32'h0000_00BB, 1'b0};
        vecs[9]  = '{3'b000, 32'h0000_5555, 32'h0,         0, 0, 1'b0, 32'h0,         1'b0};
        vecs[10] = '{3'b110, 32'h0000_6000, 32'h0,         0, 0, 1'b0, 32'h0,         1'b0};
        vecs[11] = '{3'b100, 32'h0000_0003, 32'hF00D_1234, 0, 2, !ALIGN,
                     ALIGN ? 32'h0 : 32'h0000_F00D, ALIGN};
        vecs[12] = '{3'b011, 32'h0000_0002, 32'h0080_0000, 2, 0, 1'b1, 32'hFFFF_FF80, 1'b0};
        vecs[13] = '{3'b111, 32'h0000_7000, 32'h0,         0, 0, 1'b0, 32'h0,         1'b0};
        lbu_after = '{3'b010, 32'h0000_4003, 32'h9A00_0000, 0, 0, 1'b1, 32'h0000_009A, 1'b0};

        reset_n    = 1'b0;
        req_valid  = 1'b0;
        req_addr   = 32'h0;
        req_op     = 3'b000;
        mem_gnt    = 1'b0;
        mem_rvalid = 1'b0;
        mem_rdata  = 32'h0;
        rsp_ready  = 1'b0;
        repeat (3) tick();
        reset_n = 1'b1;
        tick();

        check("reset", "req_ready", {31'b0, req_ready}, 32'd1);
        check("reset", "busy", {31'b0, busy}, 32'd0);
        check("reset", "mem_req", {31'b0, mem_req}, 32'd0);
        check("reset", "mem_addr", mem_addr, 32'h0);
        check("reset", "rsp_valid", {31'b0, rsp_valid}, 32'd0);
        check("reset", "rsp_data", rsp_data, 32'h0);
        check("reset", "rsp_err", {31'b0, rsp_err}, 32'd0);

        for (int i = 0; i < 14; i++) begin
            run_vec(vecs[i], $sformatf("vec%0d", i));
        end

        // Reset pulsed while waiting for read data; rsp_data still holds
        // the previous result so the clear is observable.
        req_valid = 1'b1;
        req_addr  = 32'h0000_3000;
        req_op    = 3'b001;
        tick();
        req_valid = 1'b0;
        check("rst_wait", "mem_req", {31'b0, mem_req}, 32'd1);
        mem_gnt = 1'b1;
        tick();
        mem_gnt = 1'b0;
        check("rst_wait", "busy_wait", {31'b0, busy}, 32'd1);
        #2 reset_n = 1'b0;
        #1;
        check("rst_wait", "mem_req", {31'b0, mem_req}, 32'd0);
        check("rst_wait", "mem_addr", mem_addr, 32'h0);
        check("rst_wait", "rsp_valid", {31'b0, rsp_valid}, 32'd0);
        check("rst_wait", "rsp_data", rsp_data, 32'h0);
        check("rst_wait", "busy", {31'b0, busy}, 32'd0);
        check("rst_wait", "req_ready", {31'b0, req_ready}, 32'd1);
        #2 reset_n = 1'b1;
        tick();
        mem_rvalid = 1'b1;
        mem_rdata  = 32'h5A5A_5A5A;
        tick();
        mem_rvalid = 1'b0;
        tick();
        check("rst_stale", "rsp_valid", {31'b0, rsp_valid}, 32'd0);
        check("rst_stale", "rsp_data", rsp_data, 32'h0);
        check("rst_stale", "busy", {31'b0, busy}, 32'd0);
        run_vec(lbu_after, "lbu_after_rst");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
